// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write (busy) scoreboard.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   we, wa, wd        writeback port (clears busy of wa)
//   ra1/ra2           read addresses -> rd1/rd2 data, busy1/busy2 flags
//   alloc_en/addr     decode marks a destination as pending
//   flush             clears every busy bit
//   busy_cnt          registered number of busy registers
//   waw               allocation hits an already-busy register this cycle
module rf_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    input  logic             flush,
    output logic [AW:0]      busy_cnt,
    output logic             waw
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    logic wr_ok;
    logic al_ok;
    logic inc;
    logic dec;

    function automatic logic writable(input logic [AW-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Write is qualified with reset so nothing is forwarded while reset is
    // held; in the sequential path reset is already low, so it is harmless.
    assign wr_ok = we && writable(wa) && !reset;
    assign al_ok = alloc_en && writable(alloc_addr) && !flush;

    // Read ports
    always_comb begin
        rd1 = mem[ra1];
        if (!writable(ra1))
            rd1 = '0;
        else if ((BYPASS != 0) && wr_ok && (wa == ra1))
            rd1 = wd;
    end

    always_comb begin
        rd2 = mem[ra2];
        if (!writable(ra2))
            rd2 = '0;
        else if ((BYPASS != 0) && wr_ok && (wa == ra2))
            rd2 = wd;
    end

    // A same-cycle write to the read address is forwarded, so not a hazard
    always_comb begin
        busy1 = busy[ra1];
        if (!writable(ra1))
            busy1 = 1'b0;
        else if ((BYPASS != 0) && wr_ok && (wa == ra1))
            busy1 = 1'b0;
    end

    always_comb begin
        busy2 = busy[ra2];
        if (!writable(ra2))
            busy2 = 1'b0;
        else if ((BYPASS != 0) && wr_ok && (wa == ra2))
            busy2 = 1'b0;
    end

    assign waw = al_ok && busy[alloc_addr];

    // Scoreboard next state: flush, then allocate, then writeback clear.
    // The allocation is written last so it wins on an address collision.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_ok)
                busy_nxt[wa] = 1'b0;
            if (al_ok)
                busy_nxt[alloc_addr] = 1'b1;
        end
    end

    // Incremental population count of the busy vector
    assign inc = al_ok && !busy[alloc_addr];
    assign dec = wr_ok && busy[wa] && !(al_ok && (alloc_addr == wa));

    always_comb begin
        cnt_nxt = busy_cnt;
        if (flush)
            cnt_nxt = '0;
        else
            cnt_nxt = busy_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard bench for rf_scoreboard (default parameters: bypass on, r0 = 0).
// Expected values are queued at drive time and compared at sample time.
module tb_rf_scoreboard;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic        waw;

    rf_scoreboard dut (
        .clk(clk), .reset(reset),
        .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .flush(flush), .busy_cnt(busy_cnt), .waw(waw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return rd1;
            1: return rd2;
            2: return {31'd0, busy1};
            3: return {31'd0, busy2};
            4: return {26'd0, busy_cnt};
            default: return {31'd0, waw};
        endcase
    endfunction

    task automatic push(input string tag, input int sel,
                        input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic m_bz(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (we && wa == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [31:0] m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        we = 0; wa = 0; wd = 0;
        alloc_en = 0; alloc_addr = 0; flush = 0;
    endtask

    // Called just after a falling edge with inputs set; ends on the next one.
    task automatic step();
        #2;
        push("rd1", 0, m_rd(ra1));
        push("rd2", 1, m_rd(ra2));
        push("busy1", 2, {31'd0, m_bz(ra1)});
        push("busy2", 3, {31'd0, m_bz(ra2)});
        push("cnt", 4, m_cnt());
        push("waw", 5, {31'd0, alloc_en && !flush &&
                        alloc_addr != 0 && m_busy[alloc_addr]});
        drain();
        @(posedge clk);
        if (we && wa != 0) m_mem[wa] = wd;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (we && wa != 0) m_busy[wa] = 1'b0;
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1; ra1 = 0; ra2 = 0;
        idle();
        m_clear();
        repeat (2) @(negedge clk);
        reset = 0;

        // reset state over all addresses
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            push("rst_rd1", 0, 32'd0);
            push("rst_b1", 2, 32'd0);
            push("rst_cnt", 4, 32'd0);
            step();
        end

        // r0 ignores writes
        we = 1; wa = 0; wd = 32'hDEADBEEF; ra1 = 0;
        push("r0_byp", 0, 32'd0);
        step();
        idle();
        push("r0_rd", 0, 32'd0);
        push("r0_cnt", 4, 32'd0);
        step();

        // bypass of r5
        we = 1; wa = 5; wd = 32'h12345678; ra1 = 5;
        push("r5_byp", 0, 32'h12345678);
        step();
        idle();
        push("r5_rd", 0, 32'h12345678);
        step();

        // alloc r7, then writeback clears it
        alloc_en = 1; alloc_addr = 7; ra1 = 7;
        step();
        idle();
        push("r7_busy", 2, 32'd1);
        push("r7_cnt", 4, 32'd1);
        step();
        we = 1; wa = 7; wd = 32'hA5A5A5A5;
        push("r7_bzbyp", 2, 32'd0);
        push("r7_rdbyp", 0, 32'hA5A5A5A5);
        step();
        idle();
        push("r7_clr", 2, 32'd0);
        push("r7_cnt0", 4, 32'd0);
        step();

        // alloc beats same-cycle write
        alloc_en = 1; alloc_addr = 9; we = 1; wa = 9; wd = 32'h1; ra1 = 9;
        step();
        idle();
        alloc_en = 1; alloc_addr = 9;
        push("r9_rd", 0, 32'h1);
        push("r9_busy", 2, 32'd1);
        push("r9_cnt", 4, 32'd1);
        push("r9_waw", 5, 32'd1);
        step();
        idle();
        push("r9_cnt2", 4, 32'd1);
        step();

        // fill scoreboard, then flush with an ignored alloc
        for (int a = 1; a < 32; a++) begin
            alloc_en = 1; alloc_addr = 5'(a);
            step();
        end
        idle();
        push("full_cnt", 4, 32'd31);
        flush = 1; alloc_en = 1; alloc_addr = 3; ra1 = 3;
        push("fl_waw", 5, 32'd0);
        step();
        idle();
        push("fl_cnt", 4, 32'd0);
        push("fl_b3", 2, 32'd0);
        step();

        // asynchronous reset between edges
        alloc_en = 1; alloc_addr = 4; we = 1; wa = 6; wd = 32'h55;
        step();
        idle();
        ra1 = 6; ra2 = 4;
        #2;
        push("pre_rd1", 0, 32'h55);
        push("pre_b2", 3, 32'd1);
        drain();
        reset = 1;
        #1;
        push("ar_rd1", 0, 32'd0);
        push("ar_b2", 3, 32'd0);
        push("ar_cnt", 4, 32'd0);
        push("ar_waw", 5, 32'd0);
        drain();
        m_clear();
        @(negedge clk);
        reset = 0;
        push("post_r6", 0, 32'd0);
        push("post_cnt", 4, 32'd0);
        step();

        // random mix against the model
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            alloc_en = 1'($urandom_range(0, 1));
            alloc_addr = 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 15) == 0);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? alloc_addr
                                              : 5'($urandom_range(0, 31));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file with a per-register pending-write scoreboard for the pipelined MIPS datapath. It has two combinational read ports, one write port and optional write-to-read bypass. A per-register busy bit is set when an instruction with a multicycle result (load, mul/div) allocates its destination, and cleared when the result is written back. The decode stage uses the busy flags for hazard stalls. Writeback drives the write port; decode drives the read and allocate ports.

## Interface
- WIDTH, 32: data width in bits.
- AW, 5: address width; depth is 2^AW registers.
- BYPASS, 1: 1 = write data forwarded to same-cycle reads of the written address; 0 = no forwarding.
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes and allocates; 0 = register 0 is ordinary.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers, busy bits and counter.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  WIDTH  write data.
- ra1, ra2  input  AW  read addresses.
- rd1, rd2  output  WIDTH  read data, combinational.
- busy1, busy2  output  1  scoreboard busy flag of ra1/ra2, combinational.
- alloc_en  input  1  mark alloc_addr as pending.
- alloc_addr  input  AW  destination being allocated.
- flush  input  1  clear all busy bits (pipeline flush).
- busy_cnt  output  AW+1  registered count of busy registers.
- waw  output  1  combinational: alloc_en to an already-busy register this cycle.

## Operation
- Writable address: any address, except address 0 when ZERO_REG=1.
- Write: on a rising edge with we=1 and a writable wa, reg[wa] <= wd. Writes to non-writable addresses are dropped.
- Read rdN:
  - 0 if ZERO_REG=1 and raN=0.
  - Otherwise wd if BYPASS=1, we=1, wa=raN and wa is writable.
  - Otherwise reg[raN].
- busyN:
  - 0 if raN is non-writable.
  - 0 if BYPASS=1, we=1 and wa=raN, because the result is forwarded.
  - Otherwise busy[raN].
- Scoreboard next state, applied in priority order at each rising edge:
  1. flush=1: all busy bits cleared. alloc_en is ignored that cycle. The write still updates data.
  2. alloc_en=1 with a writable alloc_addr: busy[alloc_addr] <= 1. This wins over a same-cycle write to the same address, since the new producer is pending.
  3. we=1 with a writable wa: busy[wa] <= 0, unless rule 2 applied to the same address.
- Re-allocating an already-busy register is legal: the bit stays 1 and waw=1 for that cycle. waw=0 when flush=1 or alloc_addr is non-writable.
- busy_cnt equals the population count of the busy bits after the edge. It is maintained incrementally:
  - +1 on allocating a non-busy register.
  - −1 on clearing a busy register.
  - Both apply for an alloc and a clear to different addresses in the same cycle.
  - Set to 0 on flush.
  - Never wraps: maximum is 2^AW, or 2^AW−1 when ZERO_REG=1.
- Reset (asynchronous): all registers 0, busy bits 0, busy_cnt 0. Consequently rd1/rd2 read 0 and busy1/busy2/waw are 0 while reset is held. Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.

## Timing
- Read latency 0: rdN and busyN follow raN combinationally.
- A write becomes visible through the array on the cycle after its rising edge. With BYPASS=1 it is also visible in the same cycle.
- An allocation is visible on busyN from the cycle after its edge.
- busy_cnt updates one edge after the causing event.
- No handshakes. The caller must hold inputs stable around the rising edge.
- Reset deassertion is synchronised externally.

## Test plan
- Reset, then read all 32 addresses → rd=0, busy=0, busy_cnt=0. Then write 0xDEADBEEF to r0 → rd1(r0)=0 and busy_cnt unchanged.
- Write 0x12345678 to r5 with ra1=5 in the same cycle:
  - BYPASS=1 → rd1=0x12345678 that cycle.
  - BYPASS=0 → rd1 shows the old value, then 0x12345678 next cycle.
- Alloc r7 → next cycle busy1(ra1=7)=1, busy_cnt=1. Then write r7=0xA5A5A5A5 → busy clears, busy_cnt=0. With BYPASS=1, busy1=0 during the write cycle.
- Same cycle: alloc r9 and write r9=0x1 → r9 holds 0x1, busy[9]=1, busy_cnt=1. Alloc r9 again → waw=1, busy_cnt stays 1.
- Alloc r1..r31 on successive cycles → busy_cnt=31. Then flush together with alloc r3 → all busy flags 0, busy_cnt=0.
- Alloc r4 and write r6=0x55, then assert reset asynchronously between edges → all outputs 0 immediately. After release, r6 reads 0 and busy_cnt=0.
